// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with debounced manual step or divided auto rate
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 0,
  parameter int DEB_CYCLES = 1250000,
  parameter int DIV        = 125000000,
  localparam int CNT_W     = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             step_btn_i,
  input  logic             mode_i,
  output logic             ser_out_o,
  output logic [CNT_W-1:0] bit_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int DIV_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic             sync1_q, sync2_q;
  logic             deb_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             step_q;

  logic             div_wrap;
  logic             advance;
  logic [CNT_W-1:0] ser_sel;

  // Debouncer runs in every state; a press finishing outside SHIFT simply evaporates.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      sync1_q <= step_btn_i;
      sync2_q <= sync1_q;
      step_q  <= 1'b0;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
          step_q    <= sync2_q;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign div_wrap = (div_q == DIV_LAST);
  assign advance  = (state_q == S_SHIFT) && (mode_i ? div_wrap : step_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    div_d     = '0;
    // Divider only counts while shifting in auto mode, so it always starts a frame at zero.
    if ((state_q == S_SHIFT) && mode_i && !div_wrap) begin
      div_d = div_q + DIV_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          shreg_d   = din_i;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (advance) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ser_sel   = (MSB_FIRST != 0) ? (LAST_IDX - bit_idx_q) : bit_idx_q;
  assign ser_out_o = (state_q == S_SHIFT) && shreg_q[ser_sel];
  assign bit_idx_o = bit_idx_q;
  assign busy_o    = (state_q == S_SHIFT);
  assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed/random bench for piso_serializer, LSB manual and MSB auto instances
module tb_piso_serializer;
  localparam int W    = 8;
  localparam int DEB  = 4;
  localparam int DV   = 5;
  localparam int HOLD = DEB + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         l_load = 1'b0, l_btn = 1'b0, l_mode = 1'b0;
  logic [W-1:0] l_din = '0;
  logic         l_ser, l_busy, l_done;
  logic [2:0]   l_idx;

  logic         m_load = 1'b0, m_btn = 1'b0, m_mode = 1'b1;
  logic [W-1:0] m_din = '0;
  logic         m_ser, m_busy, m_done;
  logic [2:0]   m_idx;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .DEB_CYCLES(DEB), .DIV(DV)) dut_l (
    .clk(clk), .rst(rst), .load_i(l_load), .din_i(l_din), .step_btn_i(l_btn),
    .mode_i(l_mode), .ser_out_o(l_ser), .bit_idx_o(l_idx), .busy_o(l_busy), .done_o(l_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .DEB_CYCLES(DEB), .DIV(DV)) dut_m (
    .clk(clk), .rst(rst), .load_i(m_load), .din_i(m_din), .step_btn_i(m_btn),
    .mode_i(m_mode), .ser_out_o(m_ser), .bit_idx_o(m_idx), .busy_o(m_busy), .done_o(m_done)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   l_done_cnt = 0;
  int   m_done_cnt = 0;
  logic l_busy_at_done = 1'b1;

  always @(negedge clk) begin
    if (l_done) begin
      l_done_cnt++;
      l_busy_at_done = l_busy;
    end
    if (m_done) m_done_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the bit that should be on the line after k advances.
  function automatic logic [31:0] ref_bit(input logic [W-1:0] w, input int k, input bit msb);
    int pos;
    pos = msb ? (W - 1 - k) : k;
    return (32'(w) >> pos) & 32'd1;
  endfunction

  task automatic press(input bit m);
    if (m) m_btn = 1'b1; else l_btn = 1'b1;
    repeat (HOLD) tick();
    if (m) m_btn = 1'b0; else l_btn = 1'b0;
    repeat (HOLD) tick();
  endtask

  task automatic do_load(input bit m, input logic [W-1:0] w);
    if (m) begin m_load = 1'b1; m_din = w; end
    else begin l_load = 1'b1; l_din = w; end
    tick();
    m_load = 1'b0;
    l_load = 1'b0;
    m_din  = W'($urandom);
    l_din  = W'($urandom);
  endtask

  task automatic frame_manual(input logic [W-1:0] w);
    int d0;
    d0 = l_done_cnt;
    do_load(0, w);
    chk("man_busy_start", 32'(l_busy), 32'd1);
    for (int k = 0; k < W; k++) begin
      chk("man_ser", 32'(l_ser), ref_bit(w, k, 0));
      chk("man_idx", 32'(l_idx), 32'(k));
      press(0);
    end
    chk("man_done_once", 32'(l_done_cnt - d0), 32'd1);
    chk("man_busy_at_done", 32'(l_busy_at_done), 32'd0);
    chk("man_idle_busy", 32'(l_busy), 32'd0);
    chk("man_idle_ser", 32'(l_ser), 32'd0);
    chk("man_idle_idx", 32'(l_idx), 32'd7);
  endtask

  task automatic frame_auto(input logic [W-1:0] w);
    int d0;
    d0 = m_done_cnt;
    do_load(1, w);
    for (int b = 0; b < W; b++) begin
      for (int c = 0; c < DV; c++) begin
        chk("auto_ser", 32'(m_ser), ref_bit(w, b, 1));
        if (c == 0) chk("auto_idx", 32'(m_idx), 32'(b));
        tick();
      end
    end
    chk("auto_done_at_40", 32'(m_done), 32'd1);
    chk("auto_busy_at_done", 32'(m_busy), 32'd0);
    chk("auto_ser_at_done", 32'(m_ser), 32'd0);
    tick();
    chk("auto_done_one_cycle", 32'(m_done), 32'd0);
    chk("auto_done_count", 32'(m_done_cnt - d0), 32'd1);
  endtask

  // Button pressed in IDLE with load asserted t edges after the press begins.
  task automatic load_during_press(input int t, input logic [W-1:0] w);
    l_btn = 1'b1;
    for (int i = 0; i < HOLD; i++) begin
      l_load = (i == t);
      l_din  = (i == t) ? w : W'($urandom);
      tick();
    end
    l_load = 1'b0;
    l_btn  = 1'b0;
    repeat (HOLD) tick();
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    int d0;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_l_ser", 32'(l_ser), 32'd0);
    chk("rst_l_busy", 32'(l_busy), 32'd0);
    chk("rst_l_done", 32'(l_done), 32'd0);
    chk("rst_l_idx", 32'(l_idx), 32'd0);
    chk("rst_m_busy", 32'(m_busy), 32'd0);
    chk("rst_m_idx", 32'(m_idx), 32'd0);
    rst = 1'b0;
    tick();

    frame_manual(8'hA5);
    frame_manual(W'($urandom));

    // Bouncing button followed by a solid hold gives a single advance.
    w = W'($urandom);
    d0 = l_done_cnt;
    do_load(0, w);
    for (int i = 0; i < 20; i++) begin
      l_btn = ((i / 2) % 2 == 0);
      tick();
    end
    l_btn = 1'b1;
    repeat (10) tick();
    chk("bounce_one_adv", 32'(l_idx), 32'd1);
    chk("bounce_ser", 32'(l_ser), ref_bit(w, 1, 0));
    repeat (100) tick();
    chk("bounce_held_100", 32'(l_idx), 32'd1);
    l_btn = 1'b0;
    repeat (HOLD) tick();
    chk("bounce_release", 32'(l_idx), 32'd1);
    for (int k = 1; k < W; k++) press(0);
    chk("bounce_done", 32'(l_done_cnt - d0), 32'd1);

    // Mid-frame load must not disturb the captured word.
    d0 = l_done_cnt;
    do_load(0, 8'hFF);
    press(0);
    press(0);
    l_load = 1'b1;
    l_din  = 8'h00;
    tick();
    l_load = 1'b0;
    chk("midload_busy", 32'(l_busy), 32'd1);
    chk("midload_idx", 32'(l_idx), 32'd2);
    for (int k = 2; k < W; k++) begin
      chk("midload_ser", 32'(l_ser), ref_bit(8'hFF, k, 0));
      press(0);
    end
    chk("midload_done", 32'(l_done_cnt - d0), 32'd1);

    // Step pulse lands on the load edge (2 sync + DEB debounce edges): load wins.
    w = W'($urandom);
    load_during_press(2 + DEB, w);
    chk("loadstep_idx", 32'(l_idx), 32'd0);
    chk("loadstep_busy", 32'(l_busy), 32'd1);
    chk("loadstep_ser", 32'(l_ser), ref_bit(w, 0, 0));
    pulse_reset();
    // One edge earlier the frame is already running when the step arrives.
    load_during_press(1 + DEB, w);
    chk("loadbefore_idx", 32'(l_idx), 32'd1);
    pulse_reset();

    // Reset abandons a frame silently.
    d0 = l_done_cnt;
    w = W'($urandom);
    do_load(0, w);
    press(0);
    press(0);
    press(0);
    chk("rstmid_pre_idx", 32'(l_idx), 32'd3);
    rst = 1'b1;
    tick();
    chk("rstmid_idx", 32'(l_idx), 32'd0);
    chk("rstmid_busy", 32'(l_busy), 32'd0);
    chk("rstmid_ser", 32'(l_ser), 32'd0);
    chk("rstmid_done", 32'(l_done), 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    chk("rstmid_no_done", 32'(l_done_cnt - d0), 32'd0);
    frame_manual(W'($urandom));

    // Auto mode, MSB first.
    frame_auto(8'h81);
    frame_auto(W'($urandom));

    // Auto to manual switch part-way through a frame.
    w = W'($urandom);
    m_mode = 1'b1;
    do_load(1, w);
    for (int i = 0; i < 30 && m_idx != 3'd2; i++) tick();
    chk("modesw_reach_2", 32'(m_idx), 32'd2);
    m_mode = 1'b0;
    repeat (30) tick();
    chk("modesw_hold_idx", 32'(m_idx), 32'd2);
    chk("modesw_ser", 32'(m_ser), ref_bit(w, 2, 1));
    press(1);
    chk("modesw_press1", 32'(m_idx), 32'd3);
    chk("modesw_ser3", 32'(m_ser), ref_bit(w, 3, 1));
    press(1);
    chk("modesw_press2", 32'(m_idx), 32'd4);
    pulse_reset();
    chk("final_m_busy", 32'(m_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
